// File: rtl/multicycle_sequencer_if.sv
// Memory handshake bundle between the multicycle sequencer and the shared
// instruction/data memory.
interface multicycle_sequencer_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  // Sequencer side: raises requests, receives ready.
  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  // Memory side: observes requests, answers with ready.
  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB over one shared memory port, with wait states,
// a bus timeout trap and a halt request honoured at instruction boundaries.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  multicycle_sequencer_if.master        bus,
  output logic                          ir_write,
  input  logic                          dec_mem_read,
  input  logic                          dec_mem_write,
  input  logic                          dec_reg_write,
  input  logic                          dec_branch,
  input  logic                          dec_jump,
  input  logic                          branch_taken,
  input  logic                          halt_req,
  output logic                          rf_we,
  output logic                          pc_write,
  output logic                          pc_sel,
  output logic                          halted,
  output logic                          bus_error,
  output logic [2:0]                    state,
  output logic [31:0]                   instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Wait-counter value seen in the last permitted un-acknowledged cycle.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             complete;
  logic             set_err;
  logic             timed_out;
  logic             imem_req_c;
  logic             dmem_req_c;
  logic             dmem_we_c;

  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TO_LAST);

  // State, wait counter, retired count and sticky bus error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      wait_cnt  <= '0;
      instret   <= '0;
      bus_error <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_cnt_d;
      if (complete) begin
        instret <= instret + 32'd1;
      end
      if (set_err) begin
        bus_error <= 1'b1;
      end
    end
  end

  // Next-state decode plus per-phase strobes; the counter defaults to zero so
  // any entry into FETCH or MEM, and any ready, starts the wait count afresh.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    complete   = 1'b0;
    set_err    = 1'b0;
    ir_write   = 1'b0;
    rf_we      = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;

    case (state_q)
      FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ready) begin
          ir_write = 1'b1;
          state_d  = DECODE;
        end else if (timed_out) begin
          state_d = HALT;
          set_err = 1'b1;
        end else begin
          state_d    = FETCH;
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
      end

      DECODE: begin
        state_d = EXEC;
      end

      EXEC: begin
        if (dec_mem_read || dec_mem_write) begin
          state_d = MEM;
        end else if (dec_reg_write) begin
          state_d = WB;
        end else begin
          complete = 1'b1;
        end
      end

      MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = dec_mem_write & ~dec_mem_read;
        if (bus.dmem_ready) begin
          if (dec_mem_read) begin
            state_d = WB;
          end else begin
            complete = 1'b1;
          end
        end else if (timed_out) begin
          state_d = HALT;
          set_err = 1'b1;
        end else begin
          state_d    = MEM;
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
      end

      WB: begin
        rf_we    = 1'b1;
        complete = 1'b1;
      end

      HALT: begin
        if (!halt_req && !bus_error) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    // Shared completion path for EXEC, MEM and WB exits.
    if (complete) begin
      pc_write = 1'b1;
      pc_sel   = dec_jump | (dec_branch & branch_taken);
      state_d  = halt_req ? HALT : FETCH;
    end

    // Nothing leaves the sequencer while reset is held, even mid-instruction.
    if (rst) begin
      ir_write   = 1'b0;
      rf_we      = 1'b0;
      pc_write   = 1'b0;
      pc_sel     = 1'b0;
      imem_req_c = 1'b0;
      dmem_req_c = 1'b0;
      dmem_we_c  = 1'b0;
    end
  end

  assign bus.imem_req = imem_req_c;
  assign bus.dmem_req = dmem_req_c;
  assign bus.dmem_we  = dmem_we_c;
  assign halted       = (state_q == HALT);
  assign state        = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: expected per-instruction
// results are queued when an instruction is set up and checked when the
// sequencer signals completion.
module tb_multicycle_sequencer;

  logic        clk;
  logic        rst;
  logic        ir_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_reg_write;
  logic        dec_branch;
  logic        dec_jump;
  logic        branch_taken;
  logic        halt_req;
  logic        rf_we;
  logic        pc_write;
  logic        pc_sel;
  logic        halted;
  logic        bus_error;
  logic [2:0]  state;
  logic [31:0] instret;

  multicycle_sequencer_if bus ();

  multicycle_sequencer #(
    .TIMEOUT(4),
    .CNT_W  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .ir_write     (ir_write),
    .dec_mem_read (dec_mem_read),
    .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write),
    .dec_branch   (dec_branch),
    .dec_jump     (dec_jump),
    .branch_taken (branch_taken),
    .halt_req     (halt_req),
    .rf_we        (rf_we),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .halted       (halted),
    .bus_error    (bus_error),
    .state        (state),
    .instret      (instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: ready after a programmable number of wait cycles, plus
  // optional stray ready levels that the sequencer must ignore.
  int   imem_lat;
  int   dmem_lat;
  int   imem_wait;
  int   dmem_wait;
  logic spur_i;
  logic spur_d;

  always @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_ready) imem_wait <= 0;
    else                                        imem_wait <= imem_wait + 1;
    if (rst || !bus.dmem_req || bus.dmem_ready) dmem_wait <= 0;
    else                                        dmem_wait <= dmem_wait + 1;
  end

  assign bus.imem_ready = (bus.imem_req && (imem_wait == imem_lat)) || spur_i;
  assign bus.dmem_ready = (bus.dmem_req && (dmem_wait == dmem_lat)) || spur_d;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  typedef struct {
    int          lat;
    logic        sel;
    int          rf;
    int          dreq;
    logic        dwe;
    logic [31:0] ins;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_instret;
  int          done_cnt = 0;

  // Queue the expected outcome of one instruction and present its decode.
  task automatic start_instr(input logic rd, input logic wr, input logic rw,
                             input logic br, input logic tk, input logic jp,
                             input int il, input int dl, input logic hlt);
    exp_t e;
    logic mem;
    mem    = rd | wr;
    e.lat  = 3 + (mem ? 1 : 0) + ((rd || (!mem && rw)) ? 1 : 0) + il + (mem ? dl : 0);
    e.sel  = jp | (br & tk);
    e.rf   = (rd || (!mem && rw)) ? 1 : 0;
    e.dreq = mem ? dl + 1 : 0;
    e.dwe  = mem & wr & ~rd;
    e.ins  = exp_instret;
    exp_q.push_back(e);
    exp_instret   = exp_instret + 32'd1;
    dec_mem_read  = rd;
    dec_mem_write = wr;
    dec_reg_write = rw;
    dec_branch    = br;
    branch_taken  = tk;
    dec_jump      = jp;
    imem_lat      = il;
    dmem_lat      = dl;
    halt_req      = hlt;
  endtask

  // Wait (bounded) for the monitor to see completion, then step past the edge.
  task automatic wait_done();
    int start;
    int b;
    start = done_cnt;
    b     = 0;
    while (done_cnt == start && b < 80) begin
      @(negedge clk);
      #1;
      b++;
    end
    if (done_cnt == start) begin
      chk("done_timeout", 0, 1);
    end else begin
      @(posedge clk);
      #1;
      chk("instret_after", instret, exp_instret);
    end
  endtask

  // Completion monitor: tracks one instruction from FETCH and compares it
  // against the head of the expectation queue when pc_write fires.
  logic in_instr = 1'b0;
  int   cyc, rf_n, ir_n, dreq_n;
  logic dwe_seen;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_instr = 1'b0;
      end else begin
        if (!in_instr && state == 3'd0) begin
          in_instr = 1'b1;
          cyc      = 0;
          rf_n     = 0;
          ir_n     = 0;
          dreq_n   = 0;
          dwe_seen = 1'b0;
        end
        if (in_instr) begin
          cyc++;
          rf_n += int'(rf_we);
          ir_n += int'(ir_write);
          if (bus.dmem_req) begin
            dreq_n++;
            if (bus.dmem_we) dwe_seen = 1'b1;
          end
          if (pc_write) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_pc_write", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("latency", cyc, e.lat);
              chk("pc_sel", pc_sel, e.sel);
              chk("rf_we_pulses", rf_n, e.rf);
              chk("ir_write_pulses", ir_n, 1);
              chk("dmem_req_cycles", dreq_n, e.dreq);
              chk("dmem_we", dwe_seen, e.dwe);
              chk("instret_at_done", instret, e.ins);
            end
            in_instr = 1'b0;
            done_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b;
    rst = 1'b1;
    dec_mem_read = 1'b0; dec_mem_write = 1'b0; dec_reg_write = 1'b0;
    dec_branch = 1'b0; dec_jump = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
    imem_lat = 0; dmem_lat = 0; spur_i = 1'b0; spur_d = 1'b0;
    exp_instret = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_state", state, 0);
    chk("rst_instret", instret, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_halted", halted, 0);
    rst = 1'b0;

    // ALU ops with both readies tied high
    spur_i = 1'b1; spur_d = 1'b1;
    repeat (2) begin
      start_instr(0, 0, 1, 0, 0, 0, 0, 0, 0);
      wait_done();
    end
    spur_i = 1'b0; spur_d = 1'b0;

    // Load, store, branches, jump, wait states incl. ready in the TIMEOUT-th cycle
    start_instr(1, 0, 1, 0, 0, 0, 0, 2, 0); wait_done();
    start_instr(0, 1, 0, 0, 0, 0, 0, 0, 0); wait_done();
    start_instr(0, 0, 0, 1, 1, 0, 0, 0, 0); wait_done();
    start_instr(0, 0, 0, 1, 0, 0, 0, 0, 0); wait_done();
    start_instr(0, 0, 1, 0, 0, 1, 0, 0, 0); wait_done();
    start_instr(0, 0, 1, 0, 0, 0, 3, 0, 0); wait_done();
    start_instr(1, 1, 1, 0, 0, 0, 0, 1, 0); wait_done();
    start_instr(0, 1, 0, 0, 0, 0, 0, 3, 0); wait_done();

    // Halt at completion, hold, then resume
    start_instr(0, 0, 1, 0, 0, 0, 0, 0, 1); wait_done();
    chk("halt_state", state, 5);
    chk("halt_flag", halted, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("halt_hold_state", state, 5);
      chk("halt_hold_instret", instret, exp_instret);
    end
    start_instr(0, 0, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("resume_fetch", state, 0);
    wait_done();

    // Fetch timeout trap
    rst = 1'b1; halt_req = 1'b1; imem_lat = 100;
    repeat (2) @(posedge clk);
    #1;
    exp_instret = '0;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("to_fetch_state", state, 0);
    end
    @(posedge clk);
    #1;
    chk("to_state", state, 5);
    chk("to_bus_error", bus_error, 1);
    chk("to_halted", halted, 1);
    chk("to_imem_req", bus.imem_req, 0);
    halt_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("to_stuck", state, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("to_rst_state", state, 0);
    chk("to_rst_bus_error", bus_error, 0);
    chk("to_rst_halted", halted, 0);
    rst = 1'b0;

    // Reset in the middle of a load's MEM phase
    start_instr(0, 0, 1, 0, 0, 0, 0, 0, 0); wait_done();
    dec_mem_read = 1'b1; dec_mem_write = 1'b0; dec_reg_write = 1'b1;
    dec_branch = 1'b0; dec_jump = 1'b0; branch_taken = 1'b0;
    imem_lat = 0; dmem_lat = 3;
    b = 0;
    @(negedge clk);
    while (state != 3'd3 && b < 20) begin
      @(negedge clk);
      b++;
    end
    chk("mem_reached", state, 3);
    chk("mem_dmem_req", bus.dmem_req, 1);
    rst = 1'b1;
    #1;
    chk("mrst_dmem_req", bus.dmem_req, 0);
    chk("mrst_pc_write", pc_write, 0);
    chk("mrst_rf_we", rf_we, 0);
    @(posedge clk);
    #1;
    chk("mrst_state", state, 0);
    chk("mrst_instret", instret, 0);
    @(negedge clk);
    chk("mrst_no_pc_write", pc_write, 0);
    chk("mrst_no_rf_we", rf_we, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
